// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined datapath: FU opcodes and PSR bit positions.
// Combinational constants only; no latency, no flow control.
package datapath_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_PASSA = 4'd6;
   localparam logic [3:0] OP_PASSB = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;

   localparam int PSR_W = 5;
   localparam int PSR_D = 4;
   localparam int PSR_V = 3;
   localparam int PSR_C = 2;
   localparam int PSR_N = 1;
   localparam int PSR_Z = 0;

endpackage

// File: rtl/datapath_pipe_alu.sv
// Combinational function unit: result plus {V,C,N,Z}; zero latency, no backpressure.
// Shifts use B[3:0]; C is the last bit shifted out (0 for a shift of zero).
module alu_param
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       vcnz
);

   localparam int MSB = WIDTH - 1;

   logic [3:0]   sh;
   logic [WIDTH:0] sum_x;
   logic [WIDTH:0] diff_x;
   logic [WIDTH:0] shl_x;
   logic [WIDTH:0] shr_x;
   logic [WIDTH:0] sra_x;
   logic         c_flag;
   logic         v_flag;

   assign sh     = b[3:0];
   assign sum_x  = {1'b0, a} + {1'b0, b};
   assign diff_x = {1'b0, a} - {1'b0, b};
   // One guard bit on the outgoing side captures the last bit shifted out.
   assign shl_x  = {1'b0, a} << sh;
   assign shr_x  = {a, 1'b0} >> sh;
   assign sra_x  = $signed({a, 1'b0}) >>> sh;

   always_comb begin
      result = a;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (opcode)
         OP_ADD: begin
            result = sum_x[WIDTH-1:0];
            c_flag = sum_x[WIDTH];
            v_flag = (a[MSB] == b[MSB]) && (sum_x[MSB] != a[MSB]);
         end
         OP_SUB: begin
            result = diff_x[WIDTH-1:0];
            c_flag = diff_x[WIDTH];
            v_flag = (a[MSB] != b[MSB]) && (diff_x[MSB] != a[MSB]);
         end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_NOT:   result = ~a;
         OP_PASSA: result = a;
         OP_PASSB: result = b;
         OP_SHL: begin
            result = shl_x[WIDTH-1:0];
            c_flag = shl_x[WIDTH];
         end
         OP_SHR: begin
            result = shr_x[WIDTH:1];
            c_flag = shr_x[0];
         end
         OP_SRA: begin
            result = sra_x[WIDTH:1];
            c_flag = sra_x[0];
         end
         default: result = a;
      endcase
   end

   assign vcnz = {v_flag, c_flag, result[MSB], (result == '0)};

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath (X: read+FU, W: writeback); result forwardable next cycle, in file after 2.
// No backpressure: one op per cycle when op_valid; DATAPATH_PIPE_FWD_EN enables W->X forwarding.
module datapath_pipe
   import datapath_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NREG   = 16,
   parameter int IR_IDX = NREG - 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   input  logic [AW-1:0]    addr_d,
   input  logic             reg_we,
   input  logic             sel_mem,
   input  logic             psr_we,
   input  logic             disp_set,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] bus_a,
   output logic [WIDTH-1:0] bus_b,
   output logic [WIDTH-1:0] instruction,
   output logic [4:0]       status
);

   localparam logic [AW-1:0] IR_A = AW'(IR_IDX);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];

   logic             wb_vld_q,  wb_vld_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic             wb_we_q,   wb_we_d;
   logic             wb_mem_q,  wb_mem_d;
   logic [WIDTH-1:0] wb_res_q,  wb_res_d;
   logic [PSR_W-1:0] psr_q,     psr_d;

   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic [WIDTH-1:0] wb_wdata;
   logic             wb_write;
   logic [WIDTH-1:0] fu_res;
   logic [3:0]       fu_vcnz;

   // Register 0 is never written, so a plain array read already yields zero for it.
   assign rd_a     = regs_q[addr_a];
   assign rd_b     = regs_q[addr_b];
   assign wb_wdata = wb_mem_q ? data_in : wb_res_q;
   assign wb_write = wb_vld_q && wb_we_q && (wb_addr_q != '0);

`ifdef DATAPATH_PIPE_FWD_EN
   logic fwd_a;
   logic fwd_b;

   assign fwd_a = wb_write && (wb_addr_q == addr_a);
   assign fwd_b = wb_write && (wb_addr_q == addr_b);
   assign bus_a = fwd_a ? wb_wdata : rd_a;
   assign bus_b = fwd_b ? wb_wdata : rd_b;
`else
   assign bus_a = rd_a;
   assign bus_b = rd_b;
`endif

   alu_param #(.WIDTH(WIDTH)) u_alu (
      .opcode (opcode),
      .a      (bus_a),
      .b      (bus_b),
      .result (fu_res),
      .vcnz   (fu_vcnz)
   );

   always_comb begin
      regs_d = regs_q;
      if (wb_write) begin
         regs_d[wb_addr_q] = wb_wdata;
      end
   end

   always_comb begin
      wb_vld_d  = op_valid;
      wb_addr_d = addr_d;
      wb_we_d   = reg_we;
      wb_mem_d  = sel_mem;
      wb_res_d  = fu_res;
   end

   always_comb begin
      psr_d = psr_q;
      if (op_valid && psr_we) begin
         psr_d[PSR_V] = fu_vcnz[PSR_V];
         psr_d[PSR_C] = fu_vcnz[PSR_C];
         psr_d[PSR_N] = fu_vcnz[PSR_N];
         psr_d[PSR_Z] = fu_vcnz[PSR_Z];
      end
      // D is sticky until reset.
      if (op_valid && disp_set) begin
         psr_d[PSR_D] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wb_vld_q  <= 1'b0;
         wb_addr_q <= '0;
         wb_we_q   <= 1'b0;
         wb_mem_q  <= 1'b0;
         wb_res_q  <= '0;
         psr_q     <= '0;
      end else begin
         regs_q    <= regs_d;
         wb_vld_q  <= wb_vld_d;
         wb_addr_q <= wb_addr_d;
         wb_we_q   <= wb_we_d;
         wb_mem_q  <= wb_mem_d;
         wb_res_q  <= wb_res_d;
         psr_q     <= psr_d;
      end
   end

   assign instruction = regs_q[IR_A];
   assign status      = psr_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed stimulus for datapath_pipe; expectations are queued with a due cycle
// and a negedge monitor compares them against the DUT outputs.
module tb_datapath_pipe;
   import datapath_pkg::*;

   localparam int SA = 0;
   localparam int SB = 1;
   localparam int SS = 2;
   localparam int SI = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [3:0]  addr_a, addr_b, addr_d;
   logic        reg_we, sel_mem, psr_we, disp_set;
   logic [3:0]  opcode;
   logic [15:0] data_in;
   logic [15:0] bus_a, bus_b, instruction;
   logic [4:0]  status;

   typedef struct {
      int          due;
      int          sig;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   datapath_pipe #(.WIDTH(16), .NREG(16), .IR_IDX(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .op_valid    (op_valid),
      .addr_a      (addr_a),
      .addr_b      (addr_b),
      .addr_d      (addr_d),
      .reg_we      (reg_we),
      .sel_mem     (sel_mem),
      .psr_we      (psr_we),
      .disp_set    (disp_set),
      .opcode      (opcode),
      .data_in     (data_in),
      .bus_a       (bus_a),
      .bus_b       (bus_b),
      .instruction (instruction),
      .status      (status)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] act(input int s);
      case (s)
         SA:      return bus_a;
         SB:      return bus_b;
         SS:      return {11'b0, status};
         default: return instruction;
      endcase
   endfunction

   function automatic string sname(input int s);
      case (s)
         SA:      return "bus_a";
         SB:      return "bus_b";
         SS:      return "status";
         default: return "instruction";
      endcase
   endfunction

   // Monitor: compare every expectation that falls due in this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            checks++;
            if (act(sb[i].sig) !== sb[i].val) begin
               errors++;
               $display("FAIL %s cycle %0d: got %h expected %h",
                        sname(sb[i].sig), cyc, act(sb[i].sig), sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s cycle %0d: expectation never sampled, expected %h",
                     sname(sb[i].sig), sb[i].due, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic expect_at(input int off, input int s, input logic [15:0] v);
      exp_t e;
      e.due = cyc + off;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic step(input logic v, input logic [3:0] op, input logic [3:0] d,
                       input logic [3:0] a, input logic [3:0] b, input logic we,
                       input logic mem, input logic pwe, input logic ds,
                       input logic [15:0] din);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      op_valid = v;
      opcode   = op;
      addr_d   = d;
      addr_a   = a;
      addr_b   = b;
      reg_we   = we;
      sel_mem  = mem;
      psr_we   = pwe;
      disp_set = ds;
      data_in  = din;
   endtask

   task automatic bubble(input logic [3:0] a, input logic [3:0] b, input logic [15:0] din);
      step(1'b0, OP_ADD, 4'd0, a, b, 1'b0, 1'b0, 1'b0, 1'b0, din);
   endtask

   // Reset with a fully active op on the inputs: reset must win.
   task automatic reset_cycle(input logic [15:0] din);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      op_valid = 1'b1;
      opcode   = OP_PASSA;
      addr_d   = 4'd3;
      addr_a   = 4'd0;
      addr_b   = 4'd0;
      reg_we   = 1'b1;
      sel_mem  = 1'b0;
      psr_we   = 1'b1;
      disp_set = 1'b1;
      data_in  = din;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; op_valid = 1'b0; opcode = '0; addr_a = '0; addr_b = '0; addr_d = '0;
      reg_we = 1'b0; sel_mem = 1'b0; psr_we = 1'b0; disp_set = 1'b0; data_in = '0;
      repeat (3) @(posedge clk);

      // Reset state
      bubble(4'd3, 4'd15, 16'h0);
      expect_at(0, SA, 16'h0); expect_at(0, SB, 16'h0);
      expect_at(0, SS, 16'h0); expect_at(0, SI, 16'h0);

      // ADD r1 = r0 + r0 -> Z
      step(1, OP_ADD, 4'd1, 4'd0, 4'd0, 1, 0, 1, 0, 16'h0);
      expect_at(1, SS, 16'h01);

      // Preload r2 = 0x7FFF, r3 = 1 via loads
      step(1, OP_PASSA, 4'd2, 4'd0, 4'd0, 1, 1, 0, 0, 16'h0);
      step(1, OP_PASSA, 4'd3, 4'd0, 4'd0, 1, 1, 0, 0, 16'h7FFF);
      bubble(4'd0, 4'd0, 16'h0001);
      expect_at(0, SS, 16'h01);

      // ADD r4 = r2 + r3 -> 0x8000, V N
      step(1, OP_ADD, 4'd4, 4'd2, 4'd3, 1, 0, 1, 0, 16'h0);
      expect_at(0, SA, 16'h7FFF); expect_at(0, SB, 16'h0001);
      expect_at(1, SS, 16'h0A);

      // ADD r5 = r4 + r4 back-to-back
      step(1, OP_ADD, 4'd5, 4'd4, 4'd4, 1, 0, 1, 0, 16'h0);
`ifdef DATAPATH_PIPE_FWD_EN
      expect_at(0, SA, 16'h8000); expect_at(1, SS, 16'h0D);
`else
      expect_at(0, SA, 16'h0000); expect_at(1, SS, 16'h01);
`endif
      bubble(4'd4, 4'd5, 16'h0);
      expect_at(0, SA, 16'h8000); expect_at(0, SB, 16'h0000);

      // Load r6 from memory; address on bus_a in the issue cycle
      step(1, OP_PASSA, 4'd6, 4'd2, 4'd0, 1, 1, 0, 0, 16'h0);
      expect_at(0, SA, 16'h7FFF);
      step(1, OP_ADD, 4'd11, 4'd0, 4'd6, 0, 0, 0, 0, 16'hBEEF);
`ifdef DATAPATH_PIPE_FWD_EN
      expect_at(0, SB, 16'hBEEF);
`else
      expect_at(0, SB, 16'h0000);
`endif
      bubble(4'd0, 4'd6, 16'h0);
      expect_at(0, SB, 16'hBEEF);

      // Register 0 ignores writes and is never forwarded
      step(1, OP_PASSA, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 16'h0);
      step(1, OP_ADD, 4'd12, 4'd0, 4'd0, 0, 0, 0, 0, 16'h1234);
      expect_at(0, SA, 16'h0); expect_at(0, SB, 16'h0);
      bubble(4'd0, 4'd0, 16'h0);
      expect_at(0, SA, 16'h0);

      // Shifts: r7 = 3, r8 = 4
      step(1, OP_PASSA, 4'd7, 4'd0, 4'd0, 1, 1, 0, 0, 16'h0);
      step(1, OP_PASSA, 4'd8, 4'd0, 4'd0, 1, 1, 0, 0, 16'h0003);
      bubble(4'd0, 4'd0, 16'h0004);
      step(1, OP_SHR, 4'd9, 4'd7, 4'd3, 1, 0, 1, 0, 16'h0);
      expect_at(0, SA, 16'h0003); expect_at(0, SB, 16'h0001);
      expect_at(1, SS, 16'h04);
      step(1, OP_SRA, 4'd10, 4'd4, 4'd8, 1, 0, 1, 0, 16'h0);
      expect_at(0, SA, 16'h8000); expect_at(0, SB, 16'h0004);
      expect_at(1, SS, 16'h02);
      bubble(4'd0, 4'd0, 16'h0);
      bubble(4'd9, 4'd10, 16'h0);
      expect_at(0, SA, 16'h0001); expect_at(0, SB, 16'hF800);

      // instruction register: visible the cycle after writeback, never forwarded
      step(1, OP_PASSA, 4'd15, 4'd0, 4'd0, 1, 1, 0, 0, 16'h0);
      expect_at(1, SI, 16'h0000); expect_at(2, SI, 16'hA5A5);
      bubble(4'd0, 4'd0, 16'hA5A5);
      bubble(4'd0, 4'd0, 16'h0);

      // D flag is sticky; VCNZ hold when psr_we is low
      step(1, OP_ADD, 4'd13, 4'd0, 4'd0, 0, 0, 0, 1, 16'h0);
      expect_at(1, SS, 16'h12);
      bubble(4'd0, 4'd0, 16'h0);
      step(1, OP_SUB, 4'd13, 4'd3, 4'd9, 0, 0, 1, 0, 16'h0);
      expect_at(0, SA, 16'h0001); expect_at(1, SS, 16'h11);
      step(1, OP_SUB, 4'd13, 4'd0, 4'd3, 0, 0, 1, 0, 16'h0);
      expect_at(1, SS, 16'h16);

      // Reset with a pending write to r3
      step(1, OP_PASSA, 4'd3, 4'd0, 4'd0, 1, 1, 0, 0, 16'h0);
      reset_cycle(16'h5555);
      bubble(4'd3, 4'd15, 16'h0);
      expect_at(0, SA, 16'h0); expect_at(0, SB, 16'h0);
      expect_at(0, SS, 16'h0); expect_at(0, SI, 16'h0);
      step(1, OP_ADD, 4'd1, 4'd3, 4'd0, 0, 0, 0, 0, 16'h0);
      expect_at(1, SS, 16'h0);

      bubble(4'd0, 4'd0, 16'h0);
      bubble(4'd0, 4'd0, 16'h0);
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Two-stage pipelined successor of the single-cycle processor datapath. Parametrised in data width and register count, with a registered execute/writeback boundary, optional operand forwarding, a zero register, and a valid-qualified issue port. It sits between the control unit, which supplies one decoded micro-operation per cycle, and main memory, which receives the address on `bus_a` and store data on `bus_b`.

## Interface
**Parameters**
- `WIDTH`, 16: data path width in bits; minimum 4.
- `NREG`, 16: number of registers; power of two, minimum 4.
- `IR_IDX`, `NREG-1`: index of the register exported as `instruction`.

**Ports**
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `op_valid`, in, 1: a micro-operation is issued this cycle.
- `addr_a`, in, log2(NREG): source A register.
- `addr_b`, in, log2(NREG): source B register.
- `addr_d`, in, log2(NREG): destination register.
- `reg_we`, in, 1: write `addr_d` at writeback.
- `sel_mem`, in, 1: writeback data comes from `data_in` (1) or from the FU result (0).
- `psr_we`, in, 1: update the V, C, N and Z flags.
- `disp_set`, in, 1: set the D flag.
- `opcode`, in, 4: FU operation.
- `data_in`, in, WIDTH: memory read data, valid in the writeback cycle.
- `bus_a`, out, WIDTH: forwarded operand A, which also serves as the memory address.
- `bus_b`, out, WIDTH: forwarded operand B, which also serves as the store data.
- `instruction`, out, WIDTH: contents of register `IR_IDX`.
- `status`, out, 5: {D, V, C, N, Z}.

## Operation
- **Stage X (issue cycle):** reads A and B and computes the FU result and flags combinationally. On the clock edge it latches {valid, `addr_d`, `reg_we`, `sel_mem`, result} into the WB register.
- **Stage W (next cycle):**
  - Write data is `data_in` if `sel_mem`, otherwise the latched result.
  - The register is written at the end of the cycle when WB valid, `reg_we` and `addr_d` != 0 all hold.
- **Register 0:** always reads 0; writes to it are dropped.
- **Forwarding:** if WB is valid, `reg_we` is set and WB `addr_d` equals `addr_a` (or `addr_b`) and is non-zero, then `bus_a` (or `bus_b`) takes the W write data instead of the file value.
- **FU opcodes:**
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS A, 7 PASS B.
  - 8 SHL A by B[3:0], 9 SHR logical, 10 SRA, 11–15 PASS A.
- **Flags:**
  - N = result MSB; Z = (result == 0).
  - C = carry-out for ADD, borrow for SUB, last bit shifted out for shifts, 0 otherwise.
  - V = signed overflow for ADD/SUB, 0 otherwise.
  - All arithmetic is modulo 2^WIDTH.
- **PSR:**
  - When `op_valid` and `psr_we`: VCNZ load at the end of stage X.
  - When `op_valid` and `disp_set`: D is set to 1.
  - D is cleared only by reset.
- **Bubbles:** when `op_valid`=0, WB valid clears and the PSR holds. The `bus_a`/`bus_b` outputs still reflect the current addresses.
- **Instruction output:** `instruction` is the raw register file content with no forwarding, so an update to it appears the cycle after writeback.

## Timing
- **Reset:** all registers, the PSR and WB valid are cleared. `status`=0 and `instruction`=0 from the first cycle after reset. A writeback pending at reset is discarded.
- **Latency:**
  - The FU result is architecturally visible to a dependent op in the next cycle (via forwarding) and in the file 2 cycles after issue.
  - Flags are visible on `status` 1 cycle after issue.
- **Memory timing:** the load address is on `bus_a` in the issue cycle; `data_in` must be valid in the following cycle. The combinational `data_in` to `bus_a`/`bus_b` path exists through forwarding.
- **Simultaneous events:**
  - A write and a read of the same register in one cycle resolve via forwarding (write-first).
  - `reset` overrides `op_valid`.
  - `psr_we` and `disp_set` together update all five flags.

## Configuration
- **`DATAPATH_PIPE_FWD_EN` defined:** forwarding is implemented as above.
- **Undefined:**
  - `bus_a`/`bus_b` show file contents only.
  - A dependent op issued the cycle directly after its producer reads the stale value; software inserts one bubble.
  - Register-0 and PSR behaviour are unchanged.

## Structure
- **Shared package (`datapath_pkg`):**
  - opcode localparams (`OP_ADD` … `OP_SRA`);
  - flag bit indices (`PSR_D`=4, `PSR_V`=3, `PSR_C`=2, `PSR_N`=1, `PSR_Z`=0).
- **Sub-module:** `alu_param` (WIDTH-parametrised combinational FU returning result and VCNZ). The register file, WB register and PSR are inline.

## Test plan
- **Reset:** assert `reset` mid-stream with a pending write to r3 → after release r3=0, `status`=0, `instruction`=0.
- **Forward:**
  - ADD r1=r0+r0 (r0=0) with `psr_we` → Z=1, N=0.
  - Preload r2=0x7FFF, r3=1; ADD r4=r2+r3 with `psr_we` → r4=0x8000, V=1, N=1, C=0, Z=0.
  - ADD r5=r4+r4 back-to-back → `bus_a`=0x8000 forwarded, r5=0, C=1, Z=1.
- **Load:** `sel_mem` op with `addr_d`=6 and `data_in`=0xBEEF in the next cycle; the next op reads r6 → `bus_b`=0xBEEF.
- **Register 0:** write 0x1234 to r0 → reads of r0 return 0, no forwarding.
- **Shift:** SHR of 0x0003 by 1 → result 0x0001, C=1. SRA of 0x8000 by 4 → 0xF800, N=1.
- **No-forward build (`DATAPATH_PIPE_FWD_EN` undefined):** a back-to-back dependent op reads the old value; with one bubble it reads the new value. `disp_set` → D=1 persists until reset.
